router_term_monitor: RTL and testbench

Synthesizable, parametrised per-terminal monitor for the mesh router's output terminals. It generalises the progress and destination checks into run-time-configurable watchdogs, with saturating statistics, sticky per-terminal error flags and first-error capture. Optional broadcast mode. It is instantiated beside the router DUT, in the bench or on silicon, and taps each terminal's data_out/pndng/pop.

---
 rtl/router_mon_pkg.sv | 36 +++
 rtl/term_watchdog.sv | 78 +++++++
 rtl/router_term_monitor.sv | 138 +++++++++++++
 tb/tb_router_term_monitor.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_mon_pkg.sv
// Shared definitions for the router terminal monitor: destination-field
// defaults, first-error codes and small arithmetic helpers.
package router_mon_pkg;

    localparam int DST_MSB_DEF = 31;
    localparam int DST_LSB_DEF = 24;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'b00,
        ERR_TO    = 2'b01,
        ERR_DEST  = 2'b10,
        ERR_PROTO = 2'b11
    } err_code_e;

    // Number of set bits in a vector of up to 64 terminals.
    function automatic logic [31:0] popcount(input logic [63:0] v);
        logic [31:0] c;
        c = '0;
        for (int i = 0; i < 64; i++) begin
            c = c + {31'd0, v[i]};
        end
        return c;
    endfunction

    // a + b clamped to the largest value representable in w bits.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int unsigned w);
        logic [32:0] s;
        logic [31:0] m;
        s = {1'b0, a} + {1'b0, b};
        m = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (s[32] || (s[31:0] > m)) ? m : s[31:0];
    endfunction

endpackage

// File: rtl/term_watchdog.sv
// Per-terminal watchdog: tracks how long a pending packet has stalled,
// checks the destination of popped packets and flags pops of an empty port.
module term_watchdog
    import router_mon_pkg::*;
#(
    parameter int              TO_W     = 8,
    parameter int              DST_W    = 8,
    parameter int              TERM_ID  = 0,
    parameter bit              BCAST_EN = 1'b0,
    parameter logic [DST_W-1:0] BCAST_ID = '1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enable_i,
    input  logic             pndng_i,
    input  logic             pop_i,
    input  logic [TO_W-1:0]  timeout_cfg_i,
    input  logic [DST_W-1:0] dest_i,
    output logic             hs_o,
    output logic             to_evt_o,
    output logic             dest_evt_o,
    output logic             proto_evt_o,
    output logic [1:0]       code_o
);

    logic [TO_W-1:0] wait_q, wait_d;
    logic            fired_q, fired_d;
    logic            clr_wait;
    logic            dest_bad;
    err_code_e       code;

    // Stall tracking, event strobes and the per-terminal priority code.
    always_comb begin
        clr_wait    = !pndng_i || pop_i || !enable_i;
        dest_bad    = (dest_i != DST_W'(TERM_ID)) && !(BCAST_EN && (dest_i == BCAST_ID));
        hs_o        = enable_i && pndng_i && pop_i;
        dest_evt_o  = hs_o && dest_bad;
        proto_evt_o = enable_i && pop_i && !pndng_i;
        // A new timeout_cfg is compared directly, so a shortened limit that
        // the counter already passed simply never matches in this episode.
        to_evt_o    = enable_i && (timeout_cfg_i != '0) && pndng_i && !pop_i &&
                      (wait_q == (timeout_cfg_i - TO_W'(1))) && !fired_q;

        code = ERR_NONE;
        if (dest_evt_o) begin
            code = ERR_DEST;
        end else if (proto_evt_o) begin
            code = ERR_PROTO;
        end else if (to_evt_o) begin
            code = ERR_TO;
        end
        code_o = code;

        wait_d  = wait_q;
        fired_d = fired_q;
        if (clr_wait) begin
            wait_d  = '0;
            fired_d = 1'b0;
        end else begin
            if (!(&wait_q)) begin
                wait_d = wait_q + TO_W'(1);
            end
            fired_d = fired_q | to_evt_o;
        end
    end

    // Stall counter and one-shot timeout latch.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_q  <= '0;
            fired_q <= 1'b0;
        end else begin
            wait_q  <= wait_d;
            fired_q <= fired_d;
        end
    end

endmodule

// File: rtl/router_term_monitor.sv
// Monitor for all mesh-router output terminals: aggregates per-terminal
// watchdog events into saturating counters, sticky flags and a capture of
// the first error seen.
module router_term_monitor
    import router_mon_pkg::*;
#(
    parameter int ROWS     = 4,
    parameter int COLUMS   = 4,
    parameter int N_TERMS  = 2*ROWS + 2*COLUMS,
    parameter int PCK_SZ   = 40,
    parameter int DST_MSB  = DST_MSB_DEF,
    parameter int DST_LSB  = DST_LSB_DEF,
    parameter int TO_W     = 8,
    parameter int CNT_W    = 16,
    parameter bit BCAST_EN = 1'b0,
    parameter logic [DST_MSB-DST_LSB:0] BCAST_ID = '1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_TERMS*PCK_SZ-1:0]  data_out,
    input  logic [N_TERMS-1:0]         pndng,
    input  logic [N_TERMS-1:0]         pop,
    input  logic                       enable,
    input  logic                       clr_stats,
    input  logic [TO_W-1:0]            timeout_cfg,
    output logic [N_TERMS-1:0]         err_sticky,
    output logic [CNT_W-1:0]           pkt_cnt,
    output logic [CNT_W-1:0]           dest_err_cnt,
    output logic [CNT_W-1:0]           timeout_cnt,
    output logic                       first_err_valid,
    output logic [$clog2(N_TERMS)-1:0] first_err_term,
    output logic [1:0]                 first_err_code
);

    localparam int DST_W  = DST_MSB - DST_LSB + 1;
    localparam int TERM_W = $clog2(N_TERMS);

    logic [N_TERMS-1:0] hs_v, to_v, dest_v, proto_v, evt_v;
    logic [1:0]         code_v [N_TERMS];

    logic [N_TERMS-1:0] sticky_q, sticky_d;
    logic [CNT_W-1:0]   pkt_q, pkt_d, dst_q, dst_d, to_q, to_d;
    logic               fe_valid_q, fe_valid_d;
    logic [TERM_W-1:0]  fe_term_q, fe_term_d;
    logic [1:0]         fe_code_q, fe_code_d;

    // Only the destination field is inspected; the rest of each packet is
    // tapped but intentionally ignored.
    logic unused_data;
    assign unused_data = ^data_out;

    for (genvar g = 0; g < N_TERMS; g++) begin : g_term
        term_watchdog #(
            .TO_W    (TO_W),
            .DST_W   (DST_W),
            .TERM_ID (g),
            .BCAST_EN(BCAST_EN),
            .BCAST_ID(BCAST_ID)
        ) u_wd (
            .clk_i        (clk),
            .rst_ni       (reset),
            .enable_i     (enable),
            .pndng_i      (pndng[g]),
            .pop_i        (pop[g]),
            .timeout_cfg_i(timeout_cfg),
            .dest_i       (data_out[g*PCK_SZ + DST_LSB +: DST_W]),
            .hs_o         (hs_v[g]),
            .to_evt_o     (to_v[g]),
            .dest_evt_o   (dest_v[g]),
            .proto_evt_o  (proto_v[g]),
            .code_o       (code_v[g])
        );
    end

    // Next-state of statistics, sticky flags and first-error capture.
    always_comb begin
        evt_v    = to_v | dest_v | proto_v;
        sticky_d = sticky_q | evt_v;
        pkt_d    = CNT_W'(sat_add(32'(pkt_q), popcount(64'(hs_v)),   CNT_W));
        dst_d    = CNT_W'(sat_add(32'(dst_q), popcount(64'(dest_v)), CNT_W));
        to_d     = CNT_W'(sat_add(32'(to_q),  popcount(64'(to_v)),   CNT_W));

        fe_valid_d = fe_valid_q;
        fe_term_d  = fe_term_q;
        fe_code_d  = fe_code_q;
        if (!fe_valid_q) begin
            // Scan high to low so the lowest-indexed event is the one kept.
            for (int i = N_TERMS - 1; i >= 0; i--) begin
                if (evt_v[i]) begin
                    fe_valid_d = 1'b1;
                    fe_term_d  = TERM_W'(i);
                    fe_code_d  = code_v[i];
                end
            end
        end

        // Clearing wins over anything that happens in the same cycle.
        if (clr_stats) begin
            sticky_d   = '0;
            pkt_d      = '0;
            dst_d      = '0;
            to_d       = '0;
            fe_valid_d = 1'b0;
            fe_term_d  = '0;
            fe_code_d  = ERR_NONE;
        end
    end

    // Registered statistics and capture state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sticky_q   <= '0;
            pkt_q      <= '0;
            dst_q      <= '0;
            to_q       <= '0;
            fe_valid_q <= 1'b0;
            fe_term_q  <= '0;
            fe_code_q  <= ERR_NONE;
        end else begin
            sticky_q   <= sticky_d;
            pkt_q      <= pkt_d;
            dst_q      <= dst_d;
            to_q       <= to_d;
            fe_valid_q <= fe_valid_d;
            fe_term_q  <= fe_term_d;
            fe_code_q  <= fe_code_d;
        end
    end

    assign err_sticky      = sticky_q;
    assign pkt_cnt         = pkt_q;
    assign dest_err_cnt    = dst_q;
    assign timeout_cnt     = to_q;
    assign first_err_valid = fe_valid_q;
    assign first_err_term  = fe_term_q;
    assign first_err_code  = fe_code_q;

endmodule

// File: tb/tb_router_term_monitor.sv
// Bench for router_term_monitor: two instances (default statistics width
// without broadcast, and 4-bit counters with broadcast) share one stimulus
// stream and are compared against a behavioural model each cycle.
module tb_router_term_monitor;

    localparam int N      = 16;
    localparam int PCK_SZ = 40;
    localparam int DLSB   = 24;

    logic            clk;
    logic            reset;
    logic [N*PCK_SZ-1:0] data_out;
    logic [N-1:0]    pndng, pop;
    logic            enable, clr_stats;
    logic [7:0]      timeout_cfg;

    logic [N-1:0]    es0, es1;
    logic [15:0]     pc0, dc0, tc0;
    logic [3:0]      pc1, dc1, tc1;
    logic            fv0, fv1;
    logic [3:0]      ft0, ft1;
    logic [1:0]      fc0, fc1;

    int checks = 0;
    int errors = 0;

    router_term_monitor u_dut0 (
        .clk(clk), .reset(reset), .data_out(data_out), .pndng(pndng), .pop(pop),
        .enable(enable), .clr_stats(clr_stats), .timeout_cfg(timeout_cfg),
        .err_sticky(es0), .pkt_cnt(pc0), .dest_err_cnt(dc0), .timeout_cnt(tc0),
        .first_err_valid(fv0), .first_err_term(ft0), .first_err_code(fc0)
    );

    router_term_monitor #(.CNT_W(4), .BCAST_EN(1'b1)) u_dut1 (
        .clk(clk), .reset(reset), .data_out(data_out), .pndng(pndng), .pop(pop),
        .enable(enable), .clr_stats(clr_stats), .timeout_cfg(timeout_cfg),
        .err_sticky(es1), .pkt_cnt(pc1), .dest_err_cnt(dc1), .timeout_cnt(tc1),
        .first_err_valid(fv1), .first_err_term(ft1), .first_err_code(fc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int         run_m   [N];
    bit         fired_m [N];
    logic [N-1:0] sticky_m [2];
    int         pkt_m [2], dst_m [2], to_m [2];
    bit         fv_m [2];
    int         ft_m [2], fc_m [2];
    int         cmax [2] = '{65535, 15};
    bit         bcen [2] = '{1'b0, 1'b1};

    task automatic model_reset();
        for (int t = 0; t < N; t++) begin
            run_m[t]   = 0;
            fired_m[t] = 0;
        end
        for (int k = 0; k < 2; k++) begin
            sticky_m[k] = '0;
            pkt_m[k] = 0; dst_m[k] = 0; to_m[k] = 0;
            fv_m[k] = 0; ft_m[k] = 0; fc_m[k] = 0;
        end
    endtask

    task automatic model_clock();
        bit to_ev [N];
        for (int t = 0; t < N; t++) begin
            to_ev[t] = enable && (timeout_cfg != 0) && pndng[t] && !pop[t] &&
                       (run_m[t] == int'(timeout_cfg) - 1) && !fired_m[t];
        end
        for (int k = 0; k < 2; k++) begin
            int nh, nd, nt, d, code;
            bit hs, bad, proto, have;
            nh = 0; nd = 0; nt = 0;
            have = fv_m[k];
            for (int t = 0; t < N; t++) begin
                d     = int'(data_out[t*PCK_SZ + DLSB +: 8]);
                hs    = enable && pndng[t] && pop[t];
                bad   = hs && (d != t) && !(bcen[k] && d == 255);
                proto = enable && pop[t] && !pndng[t];
                code  = bad ? 2 : (proto ? 3 : (to_ev[t] ? 1 : 0));
                nh += int'(hs); nd += int'(bad); nt += int'(to_ev[t]);
                if (code != 0) begin
                    sticky_m[k][t] = 1'b1;
                    if (!have) begin
                        have = 1; ft_m[k] = t; fc_m[k] = code;
                    end
                end
            end
            fv_m[k]  = have;
            pkt_m[k] = (pkt_m[k] + nh > cmax[k]) ? cmax[k] : pkt_m[k] + nh;
            dst_m[k] = (dst_m[k] + nd > cmax[k]) ? cmax[k] : dst_m[k] + nd;
            to_m[k]  = (to_m[k]  + nt > cmax[k]) ? cmax[k] : to_m[k]  + nt;
            if (clr_stats) begin
                sticky_m[k] = '0;
                pkt_m[k] = 0; dst_m[k] = 0; to_m[k] = 0;
                fv_m[k] = 0; ft_m[k] = 0; fc_m[k] = 0;
            end
        end
        for (int t = 0; t < N; t++) begin
            if (!pndng[t] || pop[t] || !enable) begin
                run_m[t] = 0; fired_m[t] = 0;
            end else begin
                run_m[t]   = (run_m[t] >= 255) ? 255 : run_m[t] + 1;
                fired_m[t] = fired_m[t] | to_ev[t];
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("sticky0", 32'(es0), 32'(sticky_m[0]));
        chk("pkt0",    32'(pc0), 32'(pkt_m[0]));
        chk("dest0",   32'(dc0), 32'(dst_m[0]));
        chk("to0",     32'(tc0), 32'(to_m[0]));
        chk("fvld0",   32'(fv0), 32'(fv_m[0]));
        chk("fterm0",  32'(ft0), 32'(ft_m[0]));
        chk("fcode0",  32'(fc0), 32'(fc_m[0]));
        chk("sticky1", 32'(es1), 32'(sticky_m[1]));
        chk("pkt1",    32'(pc1), 32'(pkt_m[1]));
        chk("dest1",   32'(dc1), 32'(dst_m[1]));
        chk("to1",     32'(tc1), 32'(to_m[1]));
        chk("fvld1",   32'(fv1), 32'(fv_m[1]));
        chk("fterm1",  32'(ft1), 32'(ft_m[1]));
        chk("fcode1",  32'(fc1), 32'(fc_m[1]));
    endtask

    task automatic step();
        @(posedge clk);
        if (!reset) model_reset();
        else        model_clock();
        #1;
        check_all();
    endtask

    task automatic set_dst(input int t, input int d);
        data_out[t*PCK_SZ + DLSB +: 8] = 8'(d);
    endtask

    task automatic rand_data();
        for (int w = 0; w < N*PCK_SZ/32; w++) data_out[w*32 +: 32] = $urandom;
    endtask

    task automatic idle();
        pndng = '0; pop = '0; clr_stats = 1'b0;
    endtask

    task automatic clear_cycle();
        idle(); clr_stats = 1'b1; step(); clr_stats = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        reset = 1'b0; enable = 1'b1; clr_stats = 1'b0; timeout_cfg = 8'd0;
        pndng = '0; pop = '0; data_out = '0;

        // Random activity while held in reset: everything must stay zero.
        for (int c = 0; c < 5; c++) begin
            rand_data();
            pndng = 16'($urandom); pop = 16'($urandom);
            clr_stats = 1'($urandom); timeout_cfg = 8'($urandom_range(1, 3));
            step();
            chk("rst_pkt0", 32'(pc0), 32'd0);
        end
        idle(); timeout_cfg = 8'd0;
        reset = 1'b1;
        for (int c = 0; c < 3; c++) step();
        chk("idle_sticky0", 32'(es0), 32'd0);

        // Timeout on terminal 3.
        timeout_cfg = 8'd4;
        pndng = 16'h0008;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (c == 4) begin
                chk("to_cnt_at4",  32'(tc0), 32'd1);
                chk("to_term_at4", 32'(ft0), 32'd3);
                chk("to_code_at4", 32'(fc0), 32'd1);
                chk("to_stk_at4",  32'(es0[3]), 32'd1);
            end
        end
        chk("to_cnt_at10", 32'(tc0), 32'd1);
        clear_cycle();

        // Destination check on terminal 5.
        pndng = 16'h0020; pop = 16'h0020; set_dst(5, 5);
        step();
        chk("dst_ok_pkt", 32'(pc0), 32'd1);
        chk("dst_ok_err", 32'(dc0), 32'd0);
        set_dst(5, 7);
        step();
        chk("dst_bad_pkt",  32'(pc0), 32'd2);
        chk("dst_bad_err",  32'(dc0), 32'd1);
        chk("dst_bad_code", 32'(fc0), 32'd2);
        clear_cycle();

        // Simultaneous bad pops on terminals 9 and 2, then one on 0.
        pndng = 16'h0204; pop = 16'h0204; set_dst(9, 8'h33); set_dst(2, 8'h33);
        step();
        chk("sim_dst", 32'(dc0), 32'd2);
        chk("sim_term", 32'(ft0), 32'd2);
        pndng = 16'h0001; pop = 16'h0001; set_dst(0, 1);
        step();
        chk("sim_keep", 32'(ft0), 32'd2);
        clear_cycle();

        // Saturation of the narrow counter, then clear racing a bad pop.
        pndng = 16'h0002; pop = 16'h0002; set_dst(1, 1);
        for (int c = 0; c < 20; c++) step();
        chk("sat_pkt1", 32'(pc1), 32'd15);
        chk("sat_pkt0", 32'(pc0), 32'd20);
        set_dst(1, 9); clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        chk("clr_pkt1", 32'(pc1), 32'd0);
        chk("clr_fv1",  32'(fv1), 32'd0);
        clear_cycle();

        // Broadcast destination and pop without pending.
        pndng = 16'h0010; pop = 16'h0010; set_dst(4, 255);
        step();
        chk("bc_dst1", 32'(dc1), 32'd0);
        chk("bc_dst0", 32'(dc0), 32'd1);
        pndng = 16'h0000; pop = 16'h0040;
        step();
        chk("proto_stk1", 32'(es1[6]), 32'd1);
        chk("proto_code1", 32'(fc1), 32'd3);
        chk("proto_pkt1", 32'(pc1), 32'd1);
        clear_cycle();

        // Randomised traffic with persistent pending, config changes,
        // occasional enable drops, clears and asynchronous resets.
        timeout_cfg = 8'd3;
        for (int c = 0; c < 600; c++) begin
            rand_data();
            for (int t = 0; t < N; t++) begin
                int r;
                if ($urandom_range(0, 7) == 0) pndng[t] = ~pndng[t];
                pop[t] = ($urandom_range(0, 5) == 0);
                r = $urandom_range(0, 9);
                if (r < 7)       set_dst(t, t);
                else if (r == 7) set_dst(t, 255);
            end
            enable    = ($urandom_range(0, 15) != 0);
            clr_stats = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 29) == 0) timeout_cfg = 8'($urandom_range(0, 6));
            reset = ($urandom_range(0, 99) != 0);
            step();
            reset = 1'b1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
